cache_ahb_burst_ctrl: RTL and testbench

- Bus-side companion of the I$/D$ cache; sits directly downstream of the cache and upstream of the AHB-Lite bus arbiter.
- Converts each cache line request (CacheBusRW fetch or writeback) into one fixed-length incrementing AHB burst.
- Supplies BeatCount/SelBusBeat so the cache can source writeback words; assembles fetched beats into FetchBuffer; returns a single-cycle CacheBusAck on completion.

---
 rtl/cache_ahb_burst_ctrl_pkg.sv | 20 ++
 rtl/cache_ahb_burst_ctrl_beat_counter.sv | 22 ++
 rtl/cache_ahb_burst_ctrl.sv | 115 +++++++++++
 tb/tb_cache_ahb_burst_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cache_ahb_burst_ctrl_pkg.sv
// Shared types and AHB-Lite encodings for the cache line burst controller.
package cache_ahb_burst_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, WRITEBACK, DONE} busstate_t;

    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;

    // Fixed-length incrementing burst code for a given beat count.
    function automatic logic [2:0] burst_code(input int beats);
        case (beats)
            4:       burst_code = 3'b011;
            8:       burst_code = 3'b101;
            16:      burst_code = 3'b111;
            default: burst_code = 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/cache_ahb_burst_ctrl_beat_counter.sv
// Beat counter with enable, synchronous clear and a terminal-count flag.
module cache_ahb_burst_ctrl_beat_counter #(
    parameter int W    = 3,
    parameter int LAST = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!reset)    cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/cache_ahb_burst_ctrl.sv
// Turns one cache line fetch/writeback into a single incrementing AHB burst.
module cache_ahb_burst_ctrl
    import cache_ahb_burst_ctrl_pkg::*;
#(
    parameter int PA_BITS = 32,
    parameter int AHBW    = 32,
    parameter int LINELEN = 256,
    parameter int LOGBWPL = $clog2(LINELEN/AHBW)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Flush,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [AHBW-1:0]    CacheReadDataWord,
    output logic               CacheBusAck,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic               SelBusBeat,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic [PA_BITS-1:0] HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HBURST,
    output logic [2:0]         HSIZE,
    output logic [AHBW-1:0]    HWDATA,
    input  logic               HREADY,
    input  logic [AHBW-1:0]    HRDATA
);

    localparam int BEATSPERLINE = LINELEN / AHBW;
    localparam int BYTESHIFT    = $clog2(AHBW / 8);

    busstate_t            state, nextState;
    logic [LOGBWPL:0]     adrBeat;
    logic                 adrEn, adrClr, adrTc;
    logic                 beatEn, beatTc;

    // Address counter is one bit wider so it can reach BEATSPERLINE (all issued).
    cache_ahb_burst_ctrl_beat_counter #(.W(LOGBWPL+1), .LAST(BEATSPERLINE)) adrCnt (
        .clk(clk), .reset(reset), .en(adrEn), .clr(adrClr), .cnt(adrBeat), .tc(adrTc)
    );

    // Data-phase counter wraps to 0 naturally after the last beat.
    cache_ahb_burst_ctrl_beat_counter #(.W(LOGBWPL), .LAST(BEATSPERLINE-1)) beatCnt (
        .clk(clk), .reset(reset), .en(beatEn), .clr(1'b0), .cnt(BeatCount), .tc(beatTc)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState   = state;
        HTRANS      = AHB_IDLE;
        HWRITE      = 1'b0;
        adrEn       = 1'b0;
        adrClr      = 1'b0;
        beatEn      = 1'b0;
        CacheBusAck = 1'b0;
        SelBusBeat  = 1'b0;
        case (state)
            IDLE: begin
                if (CacheBusRW != 2'b00 && !Flush) begin
                    HTRANS = AHB_NONSEQ;
                    HWRITE = CacheBusRW[0];
                    if (HREADY) begin
                        adrEn     = 1'b1;
                        nextState = CacheBusRW[1] ? FETCH : WRITEBACK;
                    end
                end
            end
            FETCH, WRITEBACK: begin
                SelBusBeat = 1'b1;
                HWRITE     = (state == WRITEBACK);
                if (!adrTc) HTRANS = AHB_SEQ;
                if (HREADY) begin
                    beatEn = 1'b1;
                    adrEn  = !adrTc;
                    if (beatTc) begin
                        nextState = DONE;
                        adrClr    = 1'b1;
                    end
                end
            end
            DONE: begin
                SelBusBeat  = 1'b1;
                CacheBusAck = 1'b1;
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Bus and cache handshakes stay quiet while reset is asserted.
        if (!reset) begin
            HTRANS      = AHB_IDLE;
            CacheBusAck = 1'b0;
            SelBusBeat  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            FetchBuffer <= '0;
        end else if (state == FETCH && HREADY) begin
            for (int i = 0; i < BEATSPERLINE; i++)
                if (BeatCount == LOGBWPL'(i)) FetchBuffer[i*AHBW +: AHBW] <= HRDATA;
        end
    end

    assign HADDR  = CacheBusAdr + (PA_BITS'(adrBeat) << BYTESHIFT);
    assign HWDATA = CacheReadDataWord;
    assign HBURST = burst_code(BEATSPERLINE);
    assign HSIZE  = 3'(BYTESHIFT);

endmodule

// File: tb/tb_cache_ahb_burst_ctrl.sv
// Directed and randomized bench for the cache AHB burst controller.
module tb_cache_ahb_burst_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset, Flush, HREADY;
    logic [1:0]   CacheBusRW;
    logic [31:0]  CacheBusAdr, CacheReadDataWord, HRDATA;
    logic         CacheBusAck, SelBusBeat, HWRITE;
    logic [2:0]   BeatCount, HBURST, HSIZE;
    logic [255:0] FetchBuffer;
    logic [31:0]  HADDR, HWDATA;
    logic [1:0]   HTRANS;

    cache_ahb_burst_ctrl dut (
        .clk(clk), .reset(reset), .Flush(Flush), .CacheBusRW(CacheBusRW),
        .CacheBusAdr(CacheBusAdr), .CacheReadDataWord(CacheReadDataWord),
        .CacheBusAck(CacheBusAck), .BeatCount(BeatCount), .SelBusBeat(SelBusBeat),
        .FetchBuffer(FetchBuffer), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HBURST(HBURST), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
    );

    always #5 clk = ~clk;

    // Cache side: writeback word selected by the controller's beat index.
    logic [31:0] wbLine [N];
    assign CacheReadDataWord = wbLine[BeatCount];

    // Reference model: burst progress as issued-address / completed-data counts.
    bit          mBusy, mDone, mWb;
    int          issued, completed;
    logic [31:0] expLine [N];
    int          compared = 0, mism = 0, modelAcks = 0, dutAcks = 0;

    logic [1:0]  rwReq = 2'b00;
    logic [31:0] adrReq = 32'h0;
    logic        flushReq = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 0; mDone = 0; issued = 0; completed = 0;
    endtask

    task automatic doCycle(input logic rdy, input logic rst);
        @(negedge clk);
        reset = rst; HREADY = rdy; HRDATA = $urandom;
        CacheBusRW = rwReq; CacheBusAdr = adrReq; Flush = flushReq;
        #1;
        if (CacheBusAck === 1'b1) dutAcks++;
        if (!rst) begin
            chk("rst_htrans", 64'(HTRANS), 64'd0);
            chk("rst_ack", 64'(CacheBusAck), 64'd0);
            chk("rst_sel", 64'(SelBusBeat), 64'd0);
        end else if (mDone) begin
            modelAcks++;
            chk("done_htrans", 64'(HTRANS), 64'd0);
            chk("done_ack", 64'(CacheBusAck), 64'd1);
            chk("done_sel", 64'(SelBusBeat), 64'd1);
        end else if (mBusy) begin
            chk("busy_htrans", 64'(HTRANS), (issued < N) ? 64'd3 : 64'd0);
            if (issued < N) chk("busy_haddr", 64'(HADDR), 64'(adrReq + 32'(4*issued)));
            chk("busy_hwrite", 64'(HWRITE), 64'(mWb));
            chk("busy_beat", 64'(BeatCount), 64'(completed));
            chk("busy_sel", 64'(SelBusBeat), 64'd1);
            chk("busy_ack", 64'(CacheBusAck), 64'd0);
            if (mWb) chk("busy_hwdata", 64'(HWDATA), 64'(wbLine[completed]));
        end else begin
            if (rwReq != 2'b00 && !flushReq) begin
                chk("idle_nonseq", 64'(HTRANS), 64'd2);
                chk("idle_haddr", 64'(HADDR), 64'(adrReq));
                chk("idle_hwrite", 64'(HWRITE), 64'(rwReq[0]));
            end else begin
                chk("idle_htrans", 64'(HTRANS), 64'd0);
            end
            chk("idle_ack", 64'(CacheBusAck), 64'd0);
            chk("idle_sel", 64'(SelBusBeat), 64'd0);
            chk("idle_beat", 64'(BeatCount), 64'd0);
        end
        @(posedge clk);
        if (!rst) modelReset();
        else if (mDone) mDone = 0;
        else if (mBusy) begin
            if (rdy) begin
                if (!mWb) expLine[completed] = HRDATA;
                completed++;
                if (issued < N) issued++;
                if (completed == N) begin
                    mBusy = 0; mDone = 1; issued = 0; completed = 0;
                end
            end
        end else if (rwReq != 2'b00 && !flushReq && rdy) begin
            mBusy = 1; mWb = rwReq[0]; issued = 1; completed = 0;
        end
    endtask

    task automatic runReq(input logic [1:0] rw, input logic [31:0] adr, input int stallBeat,
                          input int flushBeat, input bit randRdy, input int expLat);
        int   cyc = 0, ackCyc = -1, stallLeft = 3;
        logic rdy;
        rwReq = rw; adrReq = adr;
        while (ackCyc < 0 && cyc < 300) begin
            rdy = randRdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stallBeat >= 0 && mBusy && completed == stallBeat && stallLeft > 0) begin
                rdy = 1'b0; stallLeft--;
            end
            if (flushBeat >= 0 && mBusy && completed == flushBeat) flushReq = 1'b1;
            if (mDone) ackCyc = cyc;
            doCycle(rdy, 1'b1);
            cyc++;
        end
        if (ackCyc < 0) chk("timeout", 64'd0, 64'd1);
        if (expLat >= 0) chk("latency", 64'(ackCyc), 64'(expLat));
        rwReq = 2'b00; flushReq = 1'b0;
        if (rw[1])
            for (int k = 0; k < N; k++) chk("fetchbuf", 64'(FetchBuffer[k*32 +: 32]), 64'(expLine[k]));
    endtask

    initial begin
        int ackSnap;
        for (int k = 0; k < N; k++) wbLine[k] = 32'hA0 + 32'(k);
        modelReset();
        doCycle(1'b1, 1'b0);
        doCycle(1'b1, 1'b0);
        doCycle(1'b1, 1'b1);
        chk("hburst", 64'(HBURST), 64'd5);
        chk("hsize", 64'(HSIZE), 64'd2);
        chk("fb_reset", 64'(FetchBuffer[63:0]), 64'd0);

        runReq(2'b10, 32'h8000_1000, -1, -1, 1'b0, N+1);
        runReq(2'b01, 32'h8000_2000, -1, -1, 1'b0, N+1);
        runReq(2'b01, 32'h8000_3000, 4, -1, 1'b0, N+4);
        runReq(2'b10, 32'h8000_4000, 4, -1, 1'b0, N+4);

        // Flush in idle suppresses the burst entirely.
        ackSnap = dutAcks;
        rwReq = 2'b10; adrReq = 32'h8000_5000; flushReq = 1'b1;
        repeat (4) doCycle(1'b1, 1'b1);
        rwReq = 2'b00; flushReq = 1'b0;
        chk("flush_idle_noack", 64'(dutAcks), 64'(ackSnap));

        runReq(2'b10, 32'h8000_6000, -1, 3, 1'b0, N+1);

        // Dirty miss: writeback immediately followed by fetch.
        for (int k = 0; k < N; k++) wbLine[k] = $urandom;
        runReq(2'b01, 32'h8000_7000, -1, -1, 1'b0, N+1);
        runReq(2'b10, 32'h8000_8000, -1, -1, 1'b0, N+1);
        doCycle(1'b1, 1'b1);
        for (int k = 0; k < N; k++) chk("fb_hold", 64'(FetchBuffer[k*32 +: 32]), 64'(expLine[k]));

        // Reset in the middle of a fetch abandons it silently.
        rwReq = 2'b10; adrReq = 32'h8000_9000;
        for (int c = 0; c < 40 && !(mBusy && completed == 2); c++) doCycle(1'b1, 1'b1);
        chk("reached_beat2", 64'(completed), 64'd2);
        ackSnap = dutAcks;
        rwReq = 2'b00;
        doCycle(1'b1, 1'b0);
        repeat (5) doCycle(1'b1, 1'b1);
        chk("midrst_noack", 64'(dutAcks), 64'(ackSnap));
        chk("midrst_beat", 64'(BeatCount), 64'd0);
        chk("midrst_fb", 64'(FetchBuffer[63:0]), 64'd0);

        // Random traffic with random HREADY.
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < N; k++) wbLine[k] = $urandom;
            runReq(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
                   $urandom & 32'hFFFF_FFE0, -1, -1, 1'b1, -1);
            if ($urandom_range(0, 1) != 0) doCycle(1'b1, 1'b1);
        end

        chk("total_acks", 64'(dutAcks), 64'(modelAcks));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
